// File: rtl/uart_alu_iface_pkg.sv
// Shared definitions for the UART/ALU command stage: FSM states and ALU opcodes.
package uart_alu_iface_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Command phases during which the stage refuses new bytes.
  function automatic logic is_busy_state(input state_e s);
    return (s == CALC) || (s == SEND) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_alu_iface_timer.sv
// Inter-byte timeout counter (module rx_timeout_timer).
// Only compiled when INTERBYTE_TIMEOUT_EN is defined; the default build has no
// timeout logic at all.
`ifdef INTERBYTE_TIMEOUT_EN
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 40000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Clear on load, otherwise count up and saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/uart_alu_iface.sv
// Command stage between UART receiver/transmitter and an external combinational ALU.
// Collects operand A, operand B and opcode bytes, captures the ALU result and
// hands it to the transmitter as one byte.
// Optional macro INTERBYTE_TIMEOUT_EN: abandons a partial command after
// TIMEOUT_CYCLES of silence in WAIT_B/WAIT_OP.
module uart_alu_iface
  import uart_alu_iface_pkg::*;
#(
  parameter int unsigned NBITS          = 8,
  parameter int unsigned NBITS_OP       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 40000000
) (
  input  logic                CLK_100MHZ,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [NBITS-1:0]    rx_data,
  input  logic                tx_done_tick,
  input  logic [NBITS-1:0]    alu_result,
  output logic [NBITS-1:0]    alu_a,
  output logic [NBITS-1:0]    alu_b,
  output logic [NBITS_OP-1:0] alu_op,
  output logic                tx_start,
  output logic [NBITS-1:0]    tx_data,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [NBITS-1:0]    a_q, a_d;
  logic [NBITS-1:0]    b_q, b_d;
  logic [NBITS_OP-1:0] op_q, op_d;
  logic [NBITS-1:0]    tx_data_q, tx_data_d;
  logic                timeout;

`ifdef INTERBYTE_TIMEOUT_EN
  logic in_wait_bop;
  logic tmr_enable;

  // A byte arriving on the expiry cycle wins: counting only runs on silent cycles.
  assign in_wait_bop = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign tmr_enable  = in_wait_bop && !rx_done_tick;

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout_timer (
    .clk     (CLK_100MHZ),
    .rst_n   (reset),
    .load    (!tmr_enable),
    .enable  (tmr_enable),
    .expired (timeout)
  );
`else
  // No timeout in this build; the parameter is accepted but has no effect.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == SEND);
  assign busy     = is_busy_state(state_q);

  // Next-state and register-update decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    case (state_q)
      WAIT_A: begin
        if (rx_done_tick) begin
          a_d     = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          b_d     = rx_data;
          state_d = WAIT_OP;
        end else if (timeout) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          op_d    = rx_data[NBITS_OP-1:0];
          state_d = CALC;
        end else if (timeout) begin
          state_d = WAIT_A;
        end
      end
      CALC: begin
        tx_data_d = alu_result;
        state_d   = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_tick) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_iface.sv
// Self-checking bench for uart_alu_iface with a behavioural ALU and command model.
module tb_uart_alu_iface;
  import uart_alu_iface_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;

  int total;
  int bad;

  uart_alu_iface #(
    .NBITS(8),
    .NBITS_OP(6),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_100MHZ   (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .alu_result   (alu_result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
  endtask

  task automatic pulse_done();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs got a=%h b=%h op=%h tx=%h st=%b busy=%b want all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    total++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      bad++;
      $display("FAIL add_latch got %h/%h/%h want 05/03/20", alu_a, alu_b, alu_op);
    end
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_calc got st=%b busy=%b want st=0 busy=1", tx_start, busy);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      bad++;
      $display("FAIL add_send got st=%b tx=%h want st=1 tx=08", tx_start, tx_data);
    end
    tick();
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL add_wait_tx got st=%b busy=%b want st=0 busy=1", tx_start, busy);
    end
    pulse_done();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL add_done got busy=%b want 0", busy);
    end
  endtask

  task automatic test_drop_in_wait_tx();
    send_byte(8'hF0);
    send_byte(8'h0F);
    send_byte(8'h24);
    repeat (3) tick();
    send_byte(8'hAA);
    tick();
    total++;
    if ({alu_a, alu_b, alu_op, tx_data} !== {8'hF0, 8'h0F, 6'h24, 8'h00}) begin
      bad++;
      $display("FAIL drop_regs got %h/%h/%h tx=%h want F0/0F/24 tx=00",
               alu_a, alu_b, alu_op, tx_data);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_busy got %b want 1", busy);
    end
    pulse_done();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_done got busy=%b want 0", busy);
    end
  endtask

  task automatic test_hold_tx();
    int starts;
    int idle;
    send_byte(8'h09);
    send_byte(8'h0C);
    send_byte(8'h25);
    tick();
    starts = 0;
    idle   = 0;
    repeat (1000) begin
      tick();
      if (tx_start === 1'b1) starts++;
      if (busy !== 1'b1) idle++;
    end
    total++;
    if (starts != 0 || idle != 0) begin
      bad++;
      $display("FAIL hold_tx got extra_starts=%0d idle=%0d want 0/0", starts, idle);
    end
    total++;
    if (tx_data !== 8'h0D) begin
      bad++;
      $display("FAIL hold_tx_data got %h want 0D", tx_data);
    end
    pulse_done();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    #2;
    total++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset_mid got a=%h b=%h op=%h tx=%h st=%b busy=%b want all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy);
    end
    reset = 1'b1;
    tick();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h22);
    total++;
    if ({alu_a, alu_b, alu_op} !== {8'h01, 8'h01, 6'h22}) begin
      bad++;
      $display("FAIL reset_mid_cmd got %h/%h/%h want 01/01/22", alu_a, alu_b, alu_op);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_sub got st=%b tx=%h want st=1 tx=00", tx_start, tx_data);
    end
    tick();
    pulse_done();
  endtask

  task automatic test_back_to_back();
    send_byte(8'h30);
    send_byte(8'h03);
    send_byte(8'h02);
    tick();
    total++;
    if (tx_data !== 8'h06) begin
      bad++;
      $display("FAIL b2b_srl got %h want 06", tx_data);
    end
    tick();
    // byte arriving together with tx_done is still in WAIT_TX and is dropped
    rx_data      = 8'h99;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    // tx_done in WAIT_A and WAIT_B is ignored
    pulse_done();
    send_byte(8'h04);
    pulse_done();
    send_byte(8'h06);
    send_byte(8'hE0);
    total++;
    if ({alu_a, alu_b, alu_op} !== {8'h04, 8'h06, 6'h20}) begin
      bad++;
      $display("FAIL b2b_latch got %h/%h/%h want 04/06/20", alu_a, alu_b, alu_op);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h0A) begin
      bad++;
      $display("FAIL b2b_send got st=%b tx=%h want st=1 tx=0A", tx_start, tx_data);
    end
    tick();
    pulse_done();
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [7:0] a, b, opbyte, exp_tx;
    logic [5:0] op;
    int         starts;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    for (int n = 0; n < 24; n++) begin
      a      = 8'($urandom);
      b      = (n % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      op     = (n % 8 == 7) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      opbyte = {2'($urandom), op};
      exp_tx = alu_model(a, b, op);
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 3)) begin
          tx_done_tick = 1'($urandom);
          tick();
          tx_done_tick = 1'b0;
        end
        send_byte(k == 0 ? a : (k == 1 ? b : opbyte));
      end
      total++;
      if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin
        bad++;
        $display("FAIL rnd_latch[%0d] got %h/%h/%h want %h/%h/%h",
                 n, alu_a, alu_b, alu_op, a, b, op);
      end
      tick();
      total++;
      if (tx_start !== 1'b1 || tx_data !== exp_tx) begin
        bad++;
        $display("FAIL rnd_send[%0d] got st=%b tx=%h want st=1 tx=%h",
                 n, tx_start, tx_data, exp_tx);
      end
      starts = 0;
      repeat ($urandom_range(1, 6)) begin
        rx_done_tick = 1'($urandom);
        rx_data      = 8'($urandom);
        tick();
        rx_done_tick = 1'b0;
        if (tx_start !== 1'b0 || busy !== 1'b1) starts++;
      end
      total++;
      if (starts != 0 || {alu_a, alu_b, alu_op, tx_data} !== {a, b, op, exp_tx}) begin
        bad++;
        $display("FAIL rnd_wait_tx[%0d] got bad_cycles=%0d regs=%h/%h/%h tx=%h want 0 %h/%h/%h tx=%h",
                 n, starts, alu_a, alu_b, alu_op, tx_data, a, b, op, exp_tx);
      end
      pulse_done();
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL rnd_done[%0d] got busy=%b want 0", n, busy);
      end
    end
  endtask

`ifdef INTERBYTE_TIMEOUT_EN
  task automatic test_timeout();
    // silence in WAIT_B: partial command abandoned, alu_a kept
    send_byte(8'h07);
    repeat (TO) tick();
    total++;
    if (alu_a !== 8'h07 || busy !== 1'b0) begin
      bad++;
      $display("FAIL to_keep_a got a=%h busy=%b want 07/0", alu_a, busy);
    end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    tick();
    total++;
    if (alu_a !== 8'h02 || tx_start !== 1'b1 || tx_data !== 8'h05) begin
      bad++;
      $display("FAIL to_wait_b got a=%h st=%b tx=%h want 02/1/05", alu_a, tx_start, tx_data);
    end
    tick();
    pulse_done();
    // strobe on the expiry cycle is accepted
    send_byte(8'h07);
    repeat (TO - 1) tick();
    send_byte(8'h04);
    send_byte(8'h20);
    tick();
    total++;
    if (alu_a !== 8'h07 || tx_start !== 1'b1 || tx_data !== 8'h0B) begin
      bad++;
      $display("FAIL to_edge got a=%h st=%b tx=%h want 07/1/0B", alu_a, tx_start, tx_data);
    end
    tick();
    pulse_done();
    // silence in WAIT_OP
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO) tick();
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h20);
    tick();
    total++;
    if (alu_a !== 8'h03 || tx_start !== 1'b1 || tx_data !== 8'h07) begin
      bad++;
      $display("FAIL to_wait_op got a=%h st=%b tx=%h want 03/1/07", alu_a, tx_start, tx_data);
    end
    tick();
    pulse_done();
  endtask
`else
  task automatic test_no_timeout();
    send_byte(8'h07);
    repeat (200) tick();
    send_byte(8'h09);
    repeat (200) tick();
    send_byte(8'h20);
    tick();
    total++;
    if (alu_a !== 8'h07 || tx_start !== 1'b1 || tx_data !== 8'h10) begin
      bad++;
      $display("FAIL no_timeout got a=%h st=%b tx=%h want 07/1/10", alu_a, tx_start, tx_data);
    end
    tick();
    pulse_done();
  endtask
`endif

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    rx_data      = 8'h00;
    test_reset();
    test_add();
    test_drop_in_wait_tx();
    test_hold_tx();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef INTERBYTE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
